spmv_mem_arb: RTL
=================

Name: spmv_mem_arb

Overview:
- Shares the single DCP memory request/response port between the SpMV fetch engines: vector prefetch, column-index stream and matrix-value stream.
- Arbitrates requests, remaps each requester's local transid to a free global 6-bit transid, and routes responses back to the owner with the original local transid restored.
- Sits between the fetch engines and the DCP NoC interface.

Parameters:
NUM_REQ, 3, number of requesters; index 0 = vector prefetch, 1 = column index, 2 = matrix value
TID_W, 6, global and local transid width
MAX_OUTST, 64, outstanding-request limit; must be ≤ 2^TID_W

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
spmv_init  input  1  start of new SpMV job; clears arbitration state and error flag
req_val  input  NUM_REQ  per-requester request valid
req_rdy  output  NUM_REQ  per-requester request accepted
req_addr  input  NUM_REQ x `DCP_PADDR_MASK  per-requester line address
req_transid  input  NUM_REQ x TID_W  per-requester local transid
mem_req_rdy  input  1  memory port ready
mem_req_val  output  1  memory request valid
mem_req_transid  output  TID_W  global transid
mem_req_addr  output  `DCP_PADDR_MASK  request address
mem_resp_val  input  1  response valid
mem_resp_transid  input  TID_W  global transid of response
mem_resp_data  input  `DCP_NOC_RES_DATA_SIZE  response line
resp_val  output  NUM_REQ  one-hot response valid to owner
resp_transid  output  TID_W  restored local transid, shared by all requesters
resp_data  output  `DCP_NOC_RES_DATA_SIZE  mem_resp_data passthrough, shared
outst_cnt  output  TID_W+1  number of allocated global transids
idle  output  1  outst_cnt==0 and output stage empty
err  output  1  sticky: response arrived for an unallocated transid

Behaviour:
- Reset (async, rst_n=0): mem_req_val=0, mem_req_transid=0, mem_req_addr=0, req_rdy=0, resp_val=0, outst_cnt=0, idle=1, err=0, all table entries free, RR pointer=0.
- Output stage: single register holding {addr, global tid}. mem_req_val=1 while full. It empties on mem_req_rdy&&mem_req_val.
- Grant:
  - A grant is allowed in a cycle when the output stage is empty or draining, a free global tid exists, and outst_cnt<MAX_OUTST.
  - The granted requester is the first req_val set, searching from the RR pointer upward with wrap.
  - req_rdy is asserted only for the granted requester, combinationally.
  - On a grant the RR pointer moves to granted+1, wrapping to 0 at NUM_REQ.
- Latency: a request handshake in cycle N gives mem_req_val=1 in cycle N+1. Back-to-back requests sustain one request per cycle.
- Allocation:
  - The lowest-index free global tid is taken on grant.
  - The table entry stores {owner, local tid} and is marked busy.
  - outst_cnt increments.
- Response:
  - On mem_resp_val with a busy entry, resp_val[owner]=1 in the same cycle, combinationally.
  - resp_transid = stored local tid; resp_data = mem_resp_data.
  - The entry frees at the clock edge and is allocatable from the next cycle; outst_cnt decrements.
- Simultaneous grant and response in one cycle: outst_cnt unchanged. A tid freed this cycle is not reused this cycle.
- Response to a free entry: no resp_val, err set to 1, table and count unchanged.
- Full condition (outst_cnt==MAX_OUTST): req_rdy=0 for all requesters. The output stage still drains.
- spmv_init:
  - Clears the RR pointer and err. Table, count and output stage are unaffected.
  - Any outstanding responses still route correctly.
  - The top level asserts spmv_init only when idle=1.
- Requesters hold req_val/addr/transid stable until req_rdy; the arbiter does not check this.

Optional Feature:
- Macro: SPMV_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins, so vector prefetch always beats the streams. The RR pointer is removed and spmv_init only clears err.
- Undefined: round-robin as specified above.

Test Plan:
- Single req0, addr 0x1000, local tid 5, mem_req_rdy=1 -> next cycle mem_req_val=1, addr 0x1000, global tid 0. Response with tid 0 -> resp_val=3'b001, resp_transid=5, outst_cnt returns to 0, idle=1.
- req_val=3'b111 held, mem_req_rdy=1, no responses -> grants in order 0,1,2,0,1,2; global tids 0,1,2,3,4,5; outst_cnt=6.
- 64 grants with no responses -> all req_rdy=0 with outst_cnt=64. One response for tid 17 -> next grant receives tid 17.
- mem_req_rdy=0 for 4 cycles with req0 pending -> mem_req_val held, addr and tid stable, req_rdy=0 after first grant. rdy=1 -> accepted, next grant issues.
- Response for tid 9 with tid 9 free -> resp_val=0, err=1 and stays set. spmv_init pulse -> err=0.
- Grant and response in the same cycle with outst_cnt=3 -> outst_cnt stays 3. With SPMV_ARB_FIXED_PRIO_EN defined and req_val=3'b101 held -> req0 granted every cycle.

Source files
------------

// File: rtl/spmv_mem_arb.sv
// Arbitrates the SpMV fetch engines onto one DCP memory port, remapping local to global transids.
// Optional SPMV_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins) instead of round-robin.
`ifndef DCP_PADDR_MASK
`define DCP_PADDR_MASK 40
`endif
`ifndef DCP_NOC_RES_DATA_SIZE
`define DCP_NOC_RES_DATA_SIZE 64
`endif

module spmv_mem_arb #(
  parameter int NUM_REQ   = 3,
  parameter int TID_W     = 6,
  parameter int MAX_OUTST = 64
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      spmv_init,
  input  logic [NUM_REQ-1:0]                        req_val,
  output logic [NUM_REQ-1:0]                        req_rdy,
  input  logic [NUM_REQ-1:0][`DCP_PADDR_MASK-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][TID_W-1:0]             req_transid,
  input  logic                                      mem_req_rdy,
  output logic                                      mem_req_val,
  output logic [TID_W-1:0]                          mem_req_transid,
  output logic [`DCP_PADDR_MASK-1:0]                mem_req_addr,
  input  logic                                      mem_resp_val,
  input  logic [TID_W-1:0]                          mem_resp_transid,
  input  logic [`DCP_NOC_RES_DATA_SIZE-1:0]         mem_resp_data,
  output logic [NUM_REQ-1:0]                        resp_val,
  output logic [TID_W-1:0]                          resp_transid,
  output logic [`DCP_NOC_RES_DATA_SIZE-1:0]         resp_data,
  output logic [TID_W:0]                            outst_cnt,
  output logic                                      idle,
  output logic                                      err
);
  localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = 1 << TID_W;
  localparam int AW    = `DCP_PADDR_MASK;

  logic                 r_out_vld;
  logic [AW-1:0]        r_out_addr;
  logic [TID_W-1:0]     r_out_tid;
  logic [DEPTH-1:0]     r_busy;
  logic [IW-1:0]        r_owner [DEPTH];
  logic [TID_W-1:0]     r_ltid  [DEPTH];
  logic [TID_W:0]       r_cnt;
  logic                 r_err;

  logic                 w_free_vld;
  logic [TID_W-1:0]     w_free_tid;
  logic                 w_gnt_vld;
  logic [IW-1:0]        w_gnt_idx;
  logic                 w_can_grant;
  logic                 w_grant;
  logic                 w_resp_hit;
  logic                 w_resp_bad;
  logic [IW-1:0]        w_start;

`ifdef SPMV_ARB_FIXED_PRIO_EN
  assign w_start = '0;
`else
  logic [IW-1:0]        r_rr;
  assign w_start = r_rr;
`endif

  // Lowest free tid only looks at registered busy bits, so a tid freed this cycle waits a cycle.
  always_comb begin
    w_free_vld = 1'b0;
    w_free_tid = '0;
    for (int t = DEPTH - 1; t >= 0; t--) begin
      if (!r_busy[t]) begin
        w_free_vld = 1'b1;
        w_free_tid = TID_W'(t);
      end
    end
  end

  always_comb begin
    int j;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(w_start) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_val[j]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = IW'(j);
      end
    end
  end

  assign w_can_grant = (!r_out_vld || mem_req_rdy) && w_free_vld &&
                       (r_cnt < (TID_W+1)'(MAX_OUTST));
  assign w_grant     = w_can_grant && w_gnt_vld;
  assign w_resp_hit  = mem_resp_val && r_busy[mem_resp_transid];
  assign w_resp_bad  = mem_resp_val && !r_busy[mem_resp_transid];

  always_comb begin
    req_rdy  = '0;
    resp_val = '0;
    if (w_grant) req_rdy[w_gnt_idx] = 1'b1;
    if (w_resp_hit) resp_val[r_owner[mem_resp_transid]] = 1'b1;
  end

  assign resp_transid    = r_ltid[mem_resp_transid];
  assign resp_data       = mem_resp_data;
  assign mem_req_val     = r_out_vld;
  assign mem_req_addr    = r_out_addr;
  assign mem_req_transid = r_out_tid;
  assign outst_cnt       = r_cnt;
  assign idle            = (r_cnt == '0) && !r_out_vld;
  assign err             = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_addr <= '0;
      r_out_tid  <= '0;
      r_busy     <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      for (int t = 0; t < DEPTH; t++) begin
        r_owner[t] <= '0;
        r_ltid[t]  <= '0;
      end
    end else begin
      if (w_grant) begin
        r_out_vld           <= 1'b1;
        r_out_addr          <= req_addr[w_gnt_idx];
        r_out_tid           <= w_free_tid;
        r_busy[w_free_tid]  <= 1'b1;
        r_owner[w_free_tid] <= w_gnt_idx;
        r_ltid[w_free_tid]  <= req_transid[w_gnt_idx];
      end else if (r_out_vld && mem_req_rdy) begin
        r_out_vld <= 1'b0;
      end
      if (w_resp_hit) r_busy[mem_resp_transid] <= 1'b0;
      if (w_grant && !w_resp_hit)      r_cnt <= r_cnt + 1'b1;
      else if (!w_grant && w_resp_hit) r_cnt <= r_cnt - 1'b1;
      if (spmv_init)       r_err <= 1'b0;
      else if (w_resp_bad) r_err <= 1'b1;
    end
  end

`ifndef SPMV_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= '0;
    end else if (spmv_init) begin
      r_rr <= '0;
    end else if (w_grant) begin
      r_rr <= (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
    end
  end
`endif

endmodule
